// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester and serializer signals shared by uart_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_data;
    logic [NUM_REQ-1:0]   i_last;
    logic [NUM_REQ-1:0]   o_ack;
    logic [NUM_REQ-1:0]   o_grant;
    logic [7:0]           o_tx_data;
    logic                 o_tx_start;
    logic                 i_tx_busy;
    logic                 o_busy;

    modport master (
        input  i_req, i_data, i_last, i_tx_busy,
        output o_ack, o_grant, o_tx_data, o_tx_start, o_busy
    );

    modport slave (
        output i_req, i_data, i_last, i_tx_busy,
        input  o_ack, o_grant, o_tx_data, o_tx_start, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Packet-level round-robin arbiter sharing one UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  wire logic          i_clk,
    input  wire logic          i_reset,
    uart_tx_arbiter_if.master  bus
);
    localparam int c_PTR_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_RST = c_PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] c_ONE     = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_ack;
    logic [c_PTR_W-1:0]   r_owner;
    logic [c_PTR_W-1:0]   r_last_grant;
    logic [7:0]           r_tx_data;
    logic                 r_start;
    logic                 r_last_byte;
    logic [c_CNT_W-1:0]   r_cnt;

    logic                 w_any;
    logic [c_PTR_W-1:0]   w_win;
    logic [c_PTR_W-1:0]   w_idx;

    // Walk the search order backwards so the candidate closest to the pointer is assigned last and wins.
    always_comb begin
        w_any = 1'b0;
        w_win = r_last_grant;
        w_idx = r_last_grant;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = c_PTR_W'((int'(r_last_grant) + i) % NUM_REQ);
            if (bus.i_req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_ack        <= '0;
            r_owner      <= '0;
            r_last_grant <= c_PTR_RST;
            r_tx_data    <= 8'h00;
            r_start      <= 1'b0;
            r_last_byte  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_ack   <= '0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win;
                        r_grant <= c_ONE << w_win;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (!bus.i_req[r_owner]) begin
                        r_grant      <= '0;
                        r_last_grant <= r_owner;
                        r_state      <= S_IDLE;
                    end else if (!bus.i_tx_busy) begin
                        r_tx_data   <= bus.i_data[{r_owner, 3'b000} +: 8];
                        r_start     <= 1'b1;
                        r_ack       <= r_grant;
                        r_last_byte <= bus.i_last[r_owner];
                        r_cnt       <= '0;
                        r_state     <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    // Exiting at the maximum keeps the counter from ever wrapping.
                    if (bus.i_tx_busy || (r_cnt == c_CNT_MAX)) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.i_tx_busy) begin
                        if (r_last_byte) begin
                            r_grant      <= '0;
                            r_last_grant <= r_owner;
                            r_state      <= S_IDLE;
                        end else begin
                            r_state <= S_SEND;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ack      = r_ack;
    assign bus.o_grant    = r_grant;
    assign bus.o_tx_data  = r_tx_data;
    assign bus.o_tx_start = r_start;
    assign bus.o_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Randomized scoreboard bench for uart_tx_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int TO = 8;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] d;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    int   m_ptr;
    int   ser_en;
    int   ser_fix;

    exp_t       exp_q[$];
    logic [8:0] bq[NR][$];
    int         start_cyc[$];

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(TO)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester model: each requester presents the head of its byte queue.
    always @(negedge clk) begin
        logic [NR-1:0]   req_v;
        logic [8*NR-1:0] data_v;
        logic [NR-1:0]   last_v;
        logic [8:0]      e;
        req_v = '0; data_v = '0; last_v = '0;
        for (int k = 0; k < NR; k++) begin
            if (bus.o_ack[k] && !rst && bq[k].size() > 0) void'(bq[k].pop_front());
            if (bq[k].size() > 0) begin
                e = bq[k][0];
                req_v[k] = 1'b1;
                data_v[8*k +: 8] = e[7:0];
                last_v[k] = e[8];
            end
        end
        bus.i_req  = req_v;
        bus.i_data = data_v;
        bus.i_last = last_v;
    end

    initial begin
        int d;
        int n;
        bus.i_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start && ser_en != 0) begin
                d = (ser_fix != 0) ? 1 : $urandom_range(0, 3);
                n = (ser_fix != 0) ? ser_fix : $urandom_range(1, 12);
                repeat (d) @(negedge clk);
                bus.i_tx_busy = 1'b1;
                repeat (n) @(negedge clk);
                bus.i_tx_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t          e;
        logic [NR-1:0] eg;
        if (bus.o_tx_start) begin
            start_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_start: got data=%h grant=%b, required no start", bus.o_tx_data, bus.o_grant);
            end else begin
                e = exp_q.pop_front();
                eg = '0;
                eg[e.idx] = 1'b1;
                n_cmp++;
                if (bus.o_grant !== eg) begin
                    n_fail++;
                    $display("FAIL grant: got %b, required %b", bus.o_grant, eg);
                end
                n_cmp++;
                if (bus.o_tx_data !== e.d) begin
                    n_fail++;
                    $display("FAIL tx_data: got %h, required %h (req %0d)", bus.o_tx_data, e.d, e.idx);
                end
                n_cmp++;
                if (bus.o_ack !== eg) begin
                    n_fail++;
                    $display("FAIL ack: got %b, required %b", bus.o_ack, eg);
                end
            end
        end else if (bus.o_ack != '0) begin
            n_cmp++; n_fail++;
            $display("FAIL ack_without_start: got ack=%b, required 0", bus.o_ack);
        end
    end

    task automatic push_byte(input int k, input logic [7:0] d, input logic last);
        exp_t t;
        bq[k].push_back({last, d});
        t.idx = 3'(k);
        t.d   = d;
        exp_q.push_back(t);
    endtask

    // Reference: whole packets served round-robin among requesters with packets left.
    task automatic schedule(input int npk[NR], input int fixlen);
        int left[NR];
        int k;
        int len;
        left = npk;
        forever begin
            k = -1;
            for (int i = 1; i <= NR; i++)
                if (k < 0 && left[(m_ptr + i) % NR] > 0) k = (m_ptr + i) % NR;
            if (k < 0) break;
            len = (fixlen != 0) ? fixlen : $urandom_range(1, 4);
            for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), b == len - 1);
            left[k]--;
            m_ptr = k;
        end
    endtask

    task automatic chk(input string nm, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
        end while (!(exp_q.size() == 0 && !bus.o_busy && !bus.i_tx_busy) && n < maxc);
        n_cmp++;
        if (n >= maxc) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d bytes outstanding after %0d cycles, required 0", nm, exp_q.size(), n);
        end
        chk({nm, "_grant_clear"}, int'(bus.o_grant), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        for (int k = 0; k < NR; k++) bq[k].delete();
        m_ptr = NR - 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_grant"}, int'(bus.o_grant), 0);
        chk({nm, "_ack"}, int'(bus.o_ack), 0);
        chk({nm, "_start"}, int'(bus.o_tx_start), 0);
        chk({nm, "_data"}, int'(bus.o_tx_data), 0);
        chk({nm, "_busy"}, int'(bus.o_busy), 0);
    endtask

    initial begin
        int npk[NR];
        int n;
        int diff;
        cyc = 0; n_cmp = 0; n_fail = 0;
        m_ptr = NR - 1; ser_en = 1; ser_fix = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        rst = 1'b0;

        // Single requester, two-byte packet, 10-cycle frames.
        ser_fix = 10;
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b1);
        m_ptr = 0;
        wait_idle(500, "single");

        // Fairness from reset: expected 0,1,2,3,0,1,2,3.
        do_reset();
        ser_fix = 0;
        foreach (npk[k]) npk[k] = 2;
        schedule(npk, 1);
        wait_idle(2000, "fair");

        // Packet hold: requester 1 arrives while requester 2 owns the line.
        do_reset();
        push_byte(2, 8'hC0, 1'b0);
        push_byte(2, 8'hC1, 1'b0);
        push_byte(2, 8'hC2, 1'b1);
        n = 0;
        do begin @(posedge clk); #2; n++; end while (bus.o_grant != 4'b0100 && n < 50);
        chk("hold_grant2", int'(bus.o_grant), 4);
        push_byte(1, 8'hB1, 1'b1);
        m_ptr = 1;
        wait_idle(1000, "hold");

        for (int r = 0; r < 4; r++) begin
            foreach (npk[k]) npk[k] = $urandom_range(0, 3);
            schedule(npk, 0);
            wait_idle(4000, "random");
        end

        // Busy never rises: start-to-start spacing of a two-byte packet.
        ser_en = 0;
        start_cyc.delete();
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b1);
        m_ptr = 0;
        wait_idle(200, "timeout");
        diff = (start_cyc.size() == 2) ? start_cyc[1] - start_cyc[0] : -1;
        chk("timeout_spacing", diff, TO + 2);
        ser_en = 1;

        // Abort after the first byte, then pointer must sit at 3.
        push_byte(3, 8'h3C, 1'b0);
        m_ptr = 3;
        wait_idle(200, "abort");
        npk[0] = 1; npk[1] = 0; npk[2] = 0; npk[3] = 1;
        schedule(npk, 1);
        wait_idle(500, "post_abort");

        // Asynchronous reset while waiting for the frame to finish.
        ser_fix = 12;
        push_byte(0, 8'hA5, 1'b0);
        push_byte(0, 8'h5A, 1'b1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.i_tx_busy && n < 100);
        chk("async_busy_seen", int'(bus.i_tx_busy), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_zero("async");
        exp_q.delete();
        for (int k = 0; k < NR; k++) bq[k].delete();
        m_ptr = NR - 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        ser_fix = 0;
        npk[0] = 1; npk[1] = 1; npk[2] = 0; npk[3] = 0;
        schedule(npk, 1);
        wait_idle(500, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte-stream requesters. Grants are packet-level: once a requester wins, it keeps the transmitter until its byte flagged `last` has been fully shifted out. The block sits between the application sources and the UART TX serializer. It issues one `o_tx_start` pulse per byte and tracks the serializer's `i_tx_busy` to sequence bytes.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `BUSY_TIMEOUT`, default 64: clock cycles to wait for `i_tx_busy` to rise after a start pulse before the byte is treated as sent.
- `i_clk`, in, 1: single system clock; all state is updated on its rising edge.
- `i_reset`, in, 1: reset, asynchronous, active-high.
- `i_req`, in, NUM_REQ: per-requester "byte available" flag.
- `i_data`, in, 8*NUM_REQ: requester k's byte is on bits [8k+7:8k].
- `i_last`, in, NUM_REQ: the presented byte ends the requester's packet.
- `o_ack`, out, NUM_REQ: one-cycle pulse; the presented byte was consumed. The requester advances to its next byte.
- `o_grant`, out, NUM_REQ: one-hot current owner; all zero when idle.
- `o_tx_data`, out, 8: byte handed to the serializer; held stable until the next start.
- `o_tx_start`, out, 1: one-cycle pulse that launches transmission of `o_tx_data`.
- `i_tx_busy`, in, 1: serializer is shifting a frame.
- `o_busy`, out, 1: high whenever the state is not IDLE.

## Operation
- State machine states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- Round-robin pointer `last_grant` (log2 NUM_REQ bits). Search order is `last_grant+1`, `last_grant+2`, … modulo NUM_REQ. The first requester with `i_req` set wins.
- IDLE:
  - If any `i_req` bit is set, load the winner into `o_grant` and go to SEND.
  - Otherwise stay in IDLE.
- SEND (owner g):
  - If `i_req[g]=0`, the packet is aborted: clear `o_grant`, set `last_grant=g`, go to IDLE. No start pulse is issued.
  - Else, if `i_tx_busy=0`: register `o_tx_data=i_data[g]`, pulse `o_tx_start=1` and `o_ack[g]=1` for one cycle, latch `i_last[g]` into `last_byte`, clear the timeout counter, go to WAIT_BUSY.
  - Else (serializer still busy), stay in SEND.
- WAIT_BUSY:
  - If `i_tx_busy=1`, go to WAIT_DONE.
  - Else increment the counter. When it reaches `BUSY_TIMEOUT-1`, go to WAIT_DONE.
- WAIT_DONE:
  - Wait until `i_tx_busy=0`.
  - Then, if `last_byte=1`: clear `o_grant`, set `last_grant=g`, go to IDLE.
  - Otherwise return to SEND with the grant held.
- Requests from non-owners are ignored while a grant is held. There is no preemption.
- At most one `o_ack` bit and at most one `o_tx_start` are asserted in any cycle. `o_ack` is asserted only in the same cycle as `o_tx_start`.
- The timeout counter is `clog2(BUSY_TIMEOUT)` bits wide and saturates; it never wraps.

## Timing
- Reset values:
  - `o_grant=0`, `o_ack=0`, `o_tx_start=0`, `o_tx_data=8'h00`, `o_busy=0`.
  - State is IDLE.
  - `last_grant=NUM_REQ-1`, so requester 0 has first priority after reset.
- Reset asserted mid-packet clears everything immediately, with no further start or ack pulses. An in-flight serializer frame is not tracked.
- Latency:
  - A request sampled in IDLE at edge t makes `o_grant` valid after edge t.
  - The start pulse and ack are high for the cycle following edge t+1, provided the serializer is idle.
- Per-byte overhead: about 1 cycle in SEND plus the serializer's rise delay.
- After the last byte finishes (busy falls at edge u), the grant clears after edge u+1. The next grant is available after edge u+2.
- Simultaneous requests are resolved by pointer order in a single cycle.
- A packet abort in SEND takes effect in 1 cycle.

## Test plan
- Single requester:
  - Stimulus: `i_req=4'b0001`, bytes 0x41, 0x42 (last); serializer model with busy high for 10 cycles.
  - Response: two start pulses with `o_tx_data` 0x41 then 0x42; two acks on bit 0; grant clears after the second busy fall.
- Fairness:
  - Stimulus: all four requesting one-byte packets continuously from reset.
  - Response: grant order 0, 1, 2, 3, 0, …, with no requester served twice in a row.
- Packet hold:
  - Stimulus: requester 2 sends a 3-byte packet while requester 1 requests from the second cycle onward.
  - Response: all 3 bytes from requester 2 are sent before requester 1 is granted.
- Busy timeout:
  - Stimulus: serializer never raises busy; `BUSY_TIMEOUT=8`.
  - Response: WAIT_BUSY exits after 8 cycles; the next byte's start pulse follows within 2 cycles.
- Abort:
  - Stimulus: requester 3 drops `i_req` between bytes 1 and 2.
  - Response: grant clears, no second start pulse, `last_grant=3`.
- Async reset:
  - Stimulus: assert `i_reset` during WAIT_DONE.
  - Response: all outputs go to 0 without waiting for a clock edge; after release, requester 0 wins a tie against requester 1.
